// File: rtl/key_sdi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_sdi_ctrl
// Brief    : Secret-data-input controller for the key serial-to-parallel
//            buffer. Accepts the 32-bit SDI stream with valid/ready, parses
//            the LDKEY instruction and key segment header, forwards key data
//            words as registered write strobes and flags a complete key.
// Revision : 1.0 - initial release
// ============================================================================
module key_sdi_ctrl #(
  parameter int kd = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sdi_data,
  input  logic        sdi_valid,
  output logic        sdi_ready,
  input  logic        key_lock,
  output logic [31:0] key_word,
  output logic        key_wr,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        err
);

  // Key segment geometry: kd shares of 128 bits each.
  localparam int                WORDS     = 4 * kd;
  localparam int                CNT_W     = $clog2(WORDS) + 1;
  localparam logic [15:0]       SEG_BYTES = 16'(16 * kd);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(WORDS - 1);
  localparam logic [3:0]        OP_LDKEY  = 4'h4;
  localparam logic [3:0]        OP_KEYSEG = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic [3:0]       opcode;
  logic [15:0]      seg_len;

  // Header fields that carry no meaning for this controller.
  logic             unused_hdr_bits;
  assign unused_hdr_bits = ^sdi_data[27:16];

  assign opcode  = sdi_data[31:28];
  assign seg_len = sdi_data[15:0];

  // Ready depends only on state and lock, held low while reset is asserted.
  always_comb begin
    sdi_ready = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: sdi_ready = ~key_lock;
        ST_HDR:  sdi_ready = 1'b1;
        ST_DATA: sdi_ready = 1'b1;
        default: sdi_ready = 1'b0;
      endcase
    end
  end

  // A word moves only when both sides agree.
  always_comb begin
    xfer = sdi_valid & sdi_ready;
  end

  // Load sequencer with registered strobe, word, key-valid and error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_word  <= '0;
      key_wr    <= 1'b0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse; re-armed only by a DATA transfer.
      key_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Anything other than LDKEY is consumed and silently dropped.
          if (xfer && (opcode == OP_LDKEY)) begin
            state <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (xfer) begin
            if ((opcode == OP_KEYSEG) && (seg_len == SEG_BYTES)) begin
              state <= ST_DATA;
              cnt   <= '0;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (xfer) begin
            key_word <= sdi_data;
            key_wr   <= 1'b1;
            // Stop counting at the last index so the counter never wraps.
            if (cnt == LAST_IDX) begin
              state     <= ST_DONE;
              key_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_DONE: begin
          if (key_ack) begin
            state     <= ST_IDLE;
            key_valid <= 1'b0;
            cnt       <= '0;
          end
        end

        ST_ERR: begin
          // Sticky until reset.
          err <= 1'b1;
        end

        default: begin
          state <= ST_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/key_sdi_ctrl.md
# key_sdi_ctrl

Secret-data-input controller that sits directly upstream of the key serial-to-parallel buffer. It accepts the secret-key stream on the 32-bit SDI port with a valid/ready handshake and parses the LDKEY instruction and key segment header. It forwards only the key data words as registered write pulses for the buffer to shift in, and signals the core when a complete key (all `kd` shares) has been loaded.

## Interface
- `kd`, 1, number of 128-bit key shares; key segment = 16*kd bytes = 4*kd words.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sdi_data`  in  32  secret-data word.
- `sdi_valid`  in  1  `sdi_data` valid.
- `sdi_ready`  out  1  controller accepts word this cycle (transfer = `sdi_valid & sdi_ready`).
- `key_lock`  in  1  core is using the key; new load must not start.
- `key_word`  out  32  word to key buffer `sdi` input.
- `key_wr`  out  1  one-cycle shift strobe to key buffer `wr`.
- `key_valid`  out  1  full key loaded, held until acknowledged.
- `key_ack`  in  1  core has consumed `key_valid`.
- `err`  out  1  sticky protocol error.

## Operation
- States: IDLE, HDR, DATA, DONE, ERR. Reset -> IDLE, word counter 0.
- IDLE: `sdi_ready = ~key_lock`. On transfer: if `sdi_data[31:28] == 4'h4` (LDKEY) -> HDR; otherwise word is consumed and dropped, stay IDLE.
- HDR: `sdi_ready = 1`. On transfer: if `sdi_data[31:28] == 4'hC` (key segment) and `sdi_data[15:0] == 16*kd` -> DATA, counter cleared; else -> ERR.
- DATA: `sdi_ready = 1`. Each transfer: `key_word <= sdi_data`, `key_wr <= 1`, counter += 1. Transfer with counter == 4*kd-1 -> DONE.
- DONE: `sdi_ready = 0`, `key_valid = 1`. `key_ack` high -> IDLE.
- ERR: `sdi_ready = 0`, `err = 1`; left only via `rst`.
- `key_word` is updated only on DATA transfers; otherwise it holds its last value. `key_wr` is 0 in every cycle without a DATA transfer.
- Counter width: clog2(4*kd)+1 bits. It never exceeds 4*kd-1 and cannot wrap.
- Words are forwarded in arrival order. The buffer shifts left, so the first word received ends up in the most-significant position.

## Timing
- Reset values: `sdi_ready` 0 while `rst` is asserted, and IDLE combinational value (`~key_lock`) thereafter. `key_word` 0, `key_wr` 0, `key_valid` 0, `err` 0.
- `sdi_ready` is combinational from state and `key_lock` only, never from `sdi_valid`.
- `key_word`/`key_wr` latency: 1 cycle after the accepted DATA transfer edge.
- `key_valid` rises in the cycle after the last data transfer, coincident with the final `key_wr`. The buffer therefore holds the complete key one cycle after `key_valid` rises. The core must not sample the key before that cycle.
- Gaps (`sdi_valid` low) at any point: state and counter hold, and `key_wr` is 0.
- `key_lock` affects only IDLE. A load already past IDLE completes normally.
- `key_ack` outside DONE is ignored. `key_ack` in the same cycle `key_valid` first rises is honoured: return to IDLE on the next edge.
- Reset mid-load: immediate return to IDLE, counter 0, and outputs at reset values. Any partial key in the buffer is discarded by protocol (no `key_valid`).

## Test plan
- Nominal kd=1: send 0x40000000, 0xC0000010, then 4 words 0x00010203..0x0C0D0E0F with `sdi_valid` held high. Required: 4 `key_wr` pulses with matching `key_word`, each 1 cycle after its transfer; `key_valid` rises after the 4th; `key_ack` returns the FSM to IDLE.
- kd=2: header length 0x0020 with 8 data words. Required: exactly 8 `key_wr` pulses, then `key_valid`. Insert random `sdi_valid` gaps: no extra or missing strobes.
- Bad opcode: 0x20000000 in IDLE is consumed, with no `key_wr`, `err` stays 0. A following valid LDKEY sequence loads normally.
- Bad header: LDKEY then 0xC0000008 (kd=1). Required: `err` = 1 and `sdi_ready` = 0 until `rst`. No `key_wr` issued.
- `key_lock` high in IDLE with `sdi_valid` high: `sdi_ready` = 0 and nothing is consumed. Deassert `key_lock`: the word is accepted the same cycle.
- Assert `rst` after the 2nd data word: all outputs return to reset values at once. A fresh full sequence afterwards gives exactly 4 `key_wr` pulses and `key_valid`.
